// File: rtl/sm_mac_pkg.sv
// Shared types and constants for the sign-magnitude MAC tail.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm_mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Product magnitude width delivered by the 4-bit sign-magnitude multiplier.
  localparam int PROD_MAG_W = 6;

  // Default accumulator width and its symmetric saturation limits.
  localparam int ACC_W_DEF = 10;
  localparam int ACC_MAX   = (1 << (ACC_W_DEF - 1)) - 1;
  localparam int ACC_MIN   = -ACC_MAX;

  // Largest positive value of a symmetric two's-complement range of width w.
  function automatic int sym_limit(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sm_to_twos.sv
// Sign-magnitude to two's-complement converter; negative zero maps to 0.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
module sm_to_twos #(
  parameter int MAG_W = 6,
  parameter int OUT_W = 11
) (
  input  logic [MAG_W-1:0]        mag,
  input  logic                    sign,
  output logic signed [OUT_W-1:0] val
);

  logic signed [OUT_W-1:0] ext;

  assign ext = $signed({{(OUT_W-MAG_W){1'b0}}, mag});

  // Negate only non-zero magnitudes so a negative zero never leaks out.
  always_comb begin
    val = ext;
    if (sign && (mag != '0)) begin
      val = -ext;
    end
  end

endmodule

// File: rtl/sm_product_accumulator.sv
// Sums sign-magnitude products into a symmetric saturating accumulator, emits group total.
// Latency: result valid the cycle after the closing term is accepted; one bubble per group.
// Backpressure: in_ready is low while a result waits; out_ready stalls in DONE indefinitely.
module sm_product_accumulator
  import sm_mac_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_MAG_W-1:0] in_mag,
  input  logic                  in_sign,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-2:0]      out_mag,
  output logic                  out_sign,
  output logic                  out_sat,
  output logic [CNT_W-1:0]      out_count
);

  localparam int                LIM_I = sym_limit(ACC_W);
  localparam logic signed [ACC_W:0] LIM_P = LIM_I[ACC_W:0];
  localparam logic signed [ACC_W:0] LIM_N = -LIM_P;
  localparam logic [CNT_W-1:0]  MAX_T = CNT_W'(MAX_TERMS);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic                    sat;

  logic signed [ACC_W:0]   term;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_new;
  logic                    clamped;
  logic [CNT_W-1:0]        count_inc;
  logic                    accept;
  logic                    close;
  logic                    new_neg;
  logic [ACC_W-2:0]        new_mag;

  sm_to_twos #(
    .MAG_W (PROD_MAG_W),
    .OUT_W (ACC_W + 1)
  ) u_term (
    .mag  (in_mag),
    .sign (in_sign),
    .val  (term)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign count_inc = count + 1'b1;
  assign close     = in_last || (count_inc == MAX_T);

  // Add the term one bit wider than the accumulator, then clamp to the symmetric rail.
  always_comb begin
    sum     = $signed({acc[ACC_W-1], acc}) + term;
    acc_new = sum[ACC_W-1:0];
    clamped = 1'b0;
    if (sum > LIM_P) begin
      acc_new = LIM_P[ACC_W-1:0];
      clamped = 1'b1;
    end else if (sum < LIM_N) begin
      acc_new = LIM_N[ACC_W-1:0];
      clamped = 1'b1;
    end
  end

  // Sign-magnitude view of the new total; the clamp guarantees |acc| fits ACC_W-1 bits.
  always_comb begin
    new_neg = acc_new[ACC_W-1];
    new_mag = acc_new[ACC_W-2:0];
    if (new_neg) begin
      new_mag = (ACC_W-1)'(-acc_new);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: close a group on the accepting edge, reopen after the output handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && close) state_nxt = DONE;
      DONE:  if (out_ready)       state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulate accepted terms, snapshot the total on close, clear after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      out_mag   <= '0;
      out_sign  <= 1'b0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else if (accept) begin
      acc   <= acc_new;
      count <= count_inc;
      sat   <= sat | clamped;
      if (close) begin
        out_mag   <= new_mag;
        out_sign  <= new_neg;
        out_sat   <= sat | clamped;
        out_count <= count_inc;
      end
    end else if ((state == DONE) && out_ready) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Directed bench for sm_product_accumulator with hand-computed expected values.
// Latency: checks result visibility one cycle after the closing term.
// Backpressure: exercises out_ready stalls and the forced-close stall of a pending term.
module tb_sm_product_accumulator;

  localparam int TMO = 60;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_mag;
  logic       in_sign;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_mag;
  logic       out_sign;
  logic       out_sat;
  logic [4:0] out_count;

  int checks;
  int failures;

  sm_product_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .in_sign   (in_sign),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_sign  (out_sign),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present one term from a negedge and hold it until the edge that accepts it.
  task automatic send(input int mag, input bit sign, input bit last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_mag   = mag[5:0];
    in_sign  = sign;
    in_last  = last;
    n = 0;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must be visible on the cycle right after the closing term was accepted.
  task automatic expect_result(input string tag, input int mag, input int sign,
                               input int sat, input int cnt);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_mag"},   out_mag,   mag);
    chk({tag, "_sign"},  out_sign,  sign);
    chk({tag, "_sat"},   out_sat,   sat);
    chk({tag, "_count"}, out_count, cnt);
    chk({tag, "_inrdy"}, in_ready,  0);
  endtask

  // Complete the output handshake and confirm the block reopens.
  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_drop"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready,  1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mag    = '0;
    in_sign   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_inrdy", in_ready,  1);
    chk("rst_mag",   out_mag,   0);
    chk("rst_sign",  out_sign,  0);
    chk("rst_sat",   out_sat,   0);
    chk("rst_count", out_count, 0);

    // Basic sum: 12 - 35 + 6 = -17
    send(12, 0, 0);
    send(35, 1, 0);
    send(6,  0, 1);
    expect_result("basic", 17, 1, 0, 3);
    take("basic");

    // Negative zero normalises to +0
    send(0, 1, 1);
    expect_result("negzero", 0, 0, 0, 1);
    take("negzero");

    // Positive saturation: 11*49 = 539 clamps to 511
    for (int i = 0; i < 11; i++) send(49, 0, i == 10);
    expect_result("satpos", 511, 0, 1, 11);
    take("satpos");

    // Sat flag and acc cleared for next group
    send(5, 1, 1);
    expect_result("aftersat", 5, 1, 0, 1);
    take("aftersat");

    // Per-term clamp: rail at 511, then -49 gives 462 (not 490)
    for (int i = 0; i < 12; i++) send(49, i == 11, i == 11);
    expect_result("offrail", 462, 0, 1, 12);
    take("offrail");

    // Negative saturation: symmetric rail at -511
    for (int i = 0; i < 11; i++) send(49, 1, i == 10);
    expect_result("satneg", 511, 1, 1, 11);
    take("satneg");

    // Forced close after 16 terms without in_last
    for (int i = 0; i < 16; i++) send(1, 0, 0);
    expect_result("force", 16, 0, 0, 16);

    // 17th term presented and stalled under backpressure for 5 cycles
    in_valid = 1'b1;
    in_mag   = 6'd1;
    in_sign  = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_inrdy", in_ready,  0);
      chk("bp_mag",   out_mag,   16);
      chk("bp_count", out_count, 16);
      chk("bp_sign",  out_sign,  0);
      chk("bp_sat",   out_sat,   0);
    end
    // Handshake on the cycle out_ready rises; the pending term is not taken that edge
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_vld_drop", out_valid, 0);
    chk("bp_rdy_back", in_ready,  1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Stalled term became term 1; add 2 and close: total 3 over 2 terms
    send(2, 0, 1);
    expect_result("carry", 3, 0, 0, 2);
    take("carry");

    // Reset mid-group discards the partial sum
    send(20, 0, 0);
    send(7,  0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_inrdy", in_ready,  1);
    chk("midrst_mag",   out_mag,   0);
    chk("midrst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3, 1, 1);
    expect_result("postrst", 3, 1, 0, 1);

    // Reset while holding a result in DONE clears it asynchronously
    #1;
    rst_n = 1'b0;
    #1;
    chk("donerst_valid", out_valid, 0);
    chk("donerst_mag",   out_mag,   0);
    chk("donerst_sign",  out_sign,  0);
    chk("donerst_inrdy", in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
